pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Parametrised supervisor for a Gowin rPLL instance, clocked from the PLL reference clock.
- Drives the PLL RESET pin and synchronises the asynchronous LOCK output.
- Requires lock to be stable before releasing NUM_RST staggered domain resets.
- On lock loss: re-asserts all resets, re-arms the PLL and counts relock events. Declares a fault after repeated lock timeouts.

Parameters:
- NUM_RST, 3: number of staged reset outputs (>=1).
- PLL_RST_CYCLES, 16: clkin cycles pll_reset is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release (>=1).
- LOCK_TIMEOUT, 65536: clkin cycles allowed in WAIT_LOCK before a retry (>=2).
- RELEASE_GAP, 8: clkin cycles between successive rst_out deassertions (>=1).
- MAX_RETRIES, 4: consecutive lock timeouts that cause FAULT (>=1).
- CNT_W, 8: width of relock_count.
- SYNC_STAGES, 2: synchroniser depth for pll_lock (>=2).

Ports:
- clkin, in, 1: reference clock; the block's only clock.
- reset, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: rPLL LOCK, asynchronous to clkin.
- pll_reset, out, 1: to rPLL RESET, active-high.
- rst_out, out, NUM_RST: per-domain resets, active-high, in the clkin domain. Consumers resynchronise them into their own domains.
- locked, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- relock_count, out, CNT_W: lock-loss events since reset; saturates at 2^CNT_W-1.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Interface decision: one clock (clkin); reset is synchronous and active-high.
- Values while reset=1 and on the cycle after it:
  - state=PLL_RST, pll_reset=1, rst_out all ones, locked=0, fault=0.
  - relock_count=0; retry, timer and release counters all 0.
- reset has priority over every other event in any state.
- lock_s is pll_lock passed through SYNC_STAGES flops. Latency is SYNC_STAGES cycles; the FSM sees only lock_s.
- PLL_RST:
  - pll_reset=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the timer cleared.
  - The value of lock_s is ignored in this state.
- WAIT_LOCK:
  - pll_reset=0; the timer increments every cycle.
  - If lock_s=1, go to STABLE with the timer cleared.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1, retries is incremented. If the new retries equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - Any lock_s=0 returns to WAIT_LOCK with the timer cleared. retries is unchanged and relock_count is not incremented.
  - After LOCK_STABLE_CYCLES consecutive high cycles, go to RELEASE.
- RELEASE:
  - rst_out[i] deasserts i*RELEASE_GAP cycles after RELEASE entry; rst_out[0] deasserts on the first RELEASE cycle.
  - Bits are released in index order and stay low once released.
  - The state is left the cycle after rst_out[NUM_RST-1] falls, entering RUN. For NUM_RST=1, RELEASE lasts 1 cycle.
- RUN:
  - locked=1; retries is cleared on entry.
  - lock_s=0 means lock loss: go to PLL_RST, all rst_out=1 and locked=0 in the next cycle, relock_count +1.
- Lock loss during RELEASE is handled as in RUN: all rst_out reasserted next cycle, relock_count +1, go to PLL_RST.
- FAULT:
  - pll_reset=1, rst_out all ones, fault=1, locked=0.
  - Terminal; the only exit is reset.
- relock_count saturates and never wraps. A 1-cycle lock glitch reaching lock_s counts as a loss.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- pll_sup_pkg holds:
  - the state enum: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5;
  - a clog2-based counter-width function sized to max(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT, NUM_RST*RELEASE_GAP).
- Sub-module pll_lock_sync: SYNC_STAGES flop chain with reset to 0 and synchroniser attributes applied.

Test Plan:
Bench parameters: NUM_RST=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, RELEASE_GAP=2, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean bring-up:
  - Stimulus: release reset, raise pll_lock 10 cycles after pll_reset falls.
  - Required: pll_reset high exactly 4 cycles. rst_out goes 3'b111, then 3'b110, 3'b100, 3'b000 at 2-cycle spacing. locked=1 one cycle after rst_out=0; relock_count=0.
- Unstable lock:
  - Stimulus: drop pll_lock for 1 cycle at STABLE count 5.
  - Required: return to WAIT_LOCK; full 8 fresh high cycles needed; relock_count stays 0; rst_out stays 3'b111.
- Lock loss in RUN:
  - Stimulus: drop pll_lock while locked.
  - Required: SYNC_STAGES+1 cycles later, rst_out=3'b111, locked=0, relock_count=1, pll_reset high 4 cycles, then the normal re-release sequence.
- Timeout to fault:
  - Stimulus: hold pll_lock=0.
  - Required: two 32-cycle WAIT_LOCK windows separated by a 4-cycle PLL_RST. Then fault=1, pll_reset=1, rst_out=3'b111, held indefinitely even if pll_lock later rises.
- Loss mid-RELEASE:
  - Stimulus: drop pll_lock after rst_out=3'b110.
  - Required: rst_out back to 3'b111, relock_count +1, state PLL_RST.
- Reset mid-operation and saturation:
  - Stimulus: assert reset in RUN. Separately, run with CNT_W=2 and force 5 lock losses.
  - Required: reset gives all reset values on the next cycle. relock_count reads 3 after the 3rd loss and stays 3.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_e;

    // Width of one shared timer able to hold the largest count any state needs.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous rPLL LOCK into the clkin domain.
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises a Gowin rPLL: pulses its reset, qualifies lock, stages domain reset
// release, and recovers from (or gives up after) lock loss and lock timeouts.
module pll_lock_supervisor #(
    parameter int NUM_RST            = 3,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int RELEASE_GAP        = 8,
    parameter int MAX_RETRIES        = 4,
    parameter int CNT_W              = 8,
    parameter int SYNC_STAGES        = 2
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [NUM_RST-1:0] rst_out,
    output logic               locked,
    output logic               fault,
    output logic [CNT_W-1:0]   relock_count,
    output logic [2:0]         state_dbg
);

    import pll_sup_pkg::*;

    localparam int TW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT,
                                  NUM_RST * RELEASE_GAP);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0]    PRST_LAST   = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0]    TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0]    REL_LAST    = TW'((NUM_RST - 1) * RELEASE_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic lock_s;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RW-1:0]      retries_q, retries_d;
    logic [CNT_W-1:0]   relock_q, relock_d;
    logic               pll_reset_q, pll_reset_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               locked_q, locked_d;
    logic               fault_q, fault_d;
    logic               lost;

    pll_lock_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clkin),
        .reset(reset),
        .d    (pll_lock),
        .q    (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        retries_d = retries_q;
        relock_d  = relock_q;
        lost      = 1'b0;

        case (state_q)
            PLL_RST: begin
                if (timer_q == PRST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    timer_d   = '0;
                    retries_d = retries_q + 1'b1;
                    state_d   = (retries_d == RW'(MAX_RETRIES)) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    timer_d = '0;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (timer_q == REL_LAST) begin
                    state_d   = RUN;
                    timer_d   = '0;
                    retries_d = '0;
                end
            end
            RUN: begin
                timer_d = timer_q;
                lost    = !lock_s;
            end
            FAULT: begin
                timer_d = timer_q;
            end
            default: begin
                state_d = PLL_RST;
                timer_d = '0;
            end
        endcase

        // Lock loss after qualification re-arms the PLL and is counted, saturating.
        if (lost) begin
            state_d = PLL_RST;
            timer_d = '0;
            if (relock_q != CNT_MAX) relock_d = relock_q + 1'b1;
        end

        pll_reset_d = (state_d == PLL_RST) || (state_d == FAULT);
        locked_d    = (state_d == RUN);
        fault_d     = (state_d == FAULT);
        for (int i = 0; i < NUM_RST; i++) begin
            rst_out_d[i] = !((state_d == RUN) ||
                             ((state_d == RELEASE) && (timer_d >= TW'(i * RELEASE_GAP))));
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            retries_q   <= '0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retries_q   <= retries_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset    = pll_reset_q;
    assign rst_out      = rst_out_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: two instances (wide and 2-bit relock counters)
// share one randomized lock stimulus and are compared every cycle to a phase model.
module tb_pll_lock_supervisor;

    localparam int NUM_RST = 3;
    localparam int PRC     = 4;
    localparam int LSC     = 8;
    localparam int TMO     = 32;
    localparam int GAP     = 2;
    localparam int MAXR    = 2;
    localparam int SYNC    = 2;

    localparam int P_RST   = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_REL   = 3;
    localparam int P_RUN   = 4;
    localparam int P_FAULT = 5;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic               reset;
    logic               pll_lock;
    logic               pll_reset_a, pll_reset_b;
    logic [NUM_RST-1:0] rst_out_a, rst_out_b;
    logic               locked_a, locked_b;
    logic               fault_a, fault_b;
    logic [7:0]         relock_a;
    logic [1:0]         relock_b;
    logic [2:0]         state_a, state_b;

    pll_lock_supervisor #(
        .NUM_RST(NUM_RST), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT(TMO), .RELEASE_GAP(GAP), .MAX_RETRIES(MAXR),
        .CNT_W(8), .SYNC_STAGES(SYNC)
    ) dut_a (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .pll_reset(pll_reset_a),
        .rst_out(rst_out_a), .locked(locked_a), .fault(fault_a),
        .relock_count(relock_a), .state_dbg(state_a)
    );

    pll_lock_supervisor #(
        .NUM_RST(NUM_RST), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT(TMO), .RELEASE_GAP(GAP), .MAX_RETRIES(MAXR),
        .CNT_W(2), .SYNC_STAGES(SYNC)
    ) dut_b (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .pll_reset(pll_reset_b),
        .rst_out(rst_out_b), .locked(locked_b), .fault(fault_b),
        .relock_count(relock_b), .state_dbg(state_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Phase model: current phase, cycle index of phase entry, retry and loss tallies.
    int cyc     = 0;
    int m_ph    = P_RST;
    int m_entry = 0;
    int m_retry = 0;
    int m_loss  = 0;
    bit lock_pipe[$];

    task automatic enter(input int ph);
        m_ph    = ph;
        m_entry = cyc;
    endtask

    task automatic model_step();
        bit l;
        int n_in;
        n_in = cyc - m_entry + 1;
        cyc++;
        if (reset) begin
            lock_pipe = {};
            repeat (SYNC) lock_pipe.push_back(1'b0);
            m_retry = 0;
            m_loss  = 0;
            enter(P_RST);
            return;
        end
        l = lock_pipe.pop_front();
        lock_pipe.push_back(pll_lock);
        case (m_ph)
            P_RST:  if (n_in == PRC) enter(P_WAIT);
            P_WAIT: begin
                if (l) enter(P_STAB);
                else if (n_in == TMO) begin
                    m_retry++;
                    enter((m_retry == MAXR) ? P_FAULT : P_RST);
                end
            end
            P_STAB: begin
                if (!l) enter(P_WAIT);
                else if (n_in == LSC) enter(P_REL);
            end
            P_REL: begin
                if (!l) begin
                    m_loss++;
                    enter(P_RST);
                end else if (n_in == (NUM_RST - 1) * GAP + 1) begin
                    m_retry = 0;
                    enter(P_RUN);
                end
            end
            P_RUN: begin
                if (!l) begin
                    m_loss++;
                    enter(P_RST);
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [NUM_RST-1:0] exp_rst();
        logic [NUM_RST-1:0] r;
        for (int i = 0; i < NUM_RST; i++)
            r[i] = !((m_ph == P_RUN) || (m_ph == P_REL && (cyc - m_entry) >= i * GAP));
        return r;
    endfunction

    task automatic compare_all();
        check("state_a", state_a, m_ph);
        check("state_b", state_b, m_ph);
        check("pll_reset_a", pll_reset_a, (m_ph == P_RST || m_ph == P_FAULT));
        check("pll_reset_b", pll_reset_b, (m_ph == P_RST || m_ph == P_FAULT));
        check("rst_out_a", rst_out_a, exp_rst());
        check("rst_out_b", rst_out_b, exp_rst());
        check("locked_a", locked_a, (m_ph == P_RUN));
        check("locked_b", locked_b, (m_ph == P_RUN));
        check("fault_a", fault_a, (m_ph == P_FAULT));
        check("fault_b", fault_b, (m_ph == P_FAULT));
        check("relock_a", relock_a, (m_loss > 255) ? 255 : m_loss);
        check("relock_b", relock_b, (m_loss > 3) ? 3 : m_loss);
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_phase(input int ph, input int limit, input string tag);
        int n = 0;
        while (m_ph != ph && n < limit) begin
            tick();
            n++;
        end
        if (m_ph != ph) check(tag, m_ph, ph);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state_a, P_RST);
        check({tag, "_pll_reset"}, pll_reset_a, 1);
        check({tag, "_rst_out"}, rst_out_a, 3'b111);
        check({tag, "_locked"}, locked_a, 0);
        check({tag, "_fault"}, fault_a, 0);
        check({tag, "_relock_a"}, relock_a, 0);
        check({tag, "_relock_b"}, relock_b, 0);
    endtask

    initial begin
        int n;
        int drop;
        reset    = 1'b1;
        pll_lock = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;

        // Clean bring-up: pll_reset width, then lock 10 cycles after it falls.
        n = 0;
        while (pll_reset_a && n < 20) begin
            n++;
            tick();
        end
        check("prst_len", n, PRC);
        repeat (9) tick();
        pll_lock = 1'b1;

        // Unstable lock: one-cycle dropout reaching the FSM at STABLE count 5.
        wait_phase(P_STAB, 50, "wait_stable");
        n = 0;
        while (!(m_ph == P_STAB && (cyc - m_entry) == 3) && n < 50) begin
            tick();
            n++;
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_phase(P_WAIT, 10, "unstable_wait");
        check("unstable_rst", rst_out_a, 3'b111);
        check("unstable_relock", relock_a, 0);
        wait_phase(P_RUN, 100, "first_run");
        check("first_run_relock", relock_a, 0);

        // Repeated lock losses in RUN; also saturates the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(1, 20)) tick();
            drop = $urandom_range(1, 3);
            pll_lock = 1'b0;
            for (int j = 1; j <= SYNC + 1; j++) begin
                tick();
                if (j == drop) pll_lock = 1'b1;
            end
            pll_lock = 1'b1;
            check("loss_rst", rst_out_a, 3'b111);
            check("loss_locked", locked_a, 0);
            check("loss_cnt_b", relock_b, (k + 1 > 3) ? 3 : k + 1);
            wait_phase(P_RUN, 200, "relock_run");
        end
        check("sat_b", relock_b, 3);
        check("cnt_a", relock_a, 5);

        // Loss while rst_out = 3'b110.
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_phase(P_REL, 200, "wait_release");
        check("rel_first", rst_out_a, 3'b110);
        pll_lock = 1'b0;
        repeat (SYNC + 1) tick();
        pll_lock = 1'b1;
        check("midrel_rst", rst_out_a, 3'b111);
        check("midrel_state", state_a, P_RST);
        check("midrel_cnt", relock_a, 7);

        // Reset while running.
        wait_phase(P_RUN, 200, "run_before_reset");
        reset = 1'b1;
        tick();
        check_reset_vals("midrun_reset");
        reset = 1'b0;

        // Random soak with lock biased high.
        repeat (60) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) tick();
        end

        // Timeout to fault.
        reset = 1'b1;
        pll_lock = 1'b0;
        tick();
        reset = 1'b0;
        n = 0;
        while (!fault_a && n < 200) begin
            tick();
            n++;
        end
        check("fault_delay", n, 2 * (PRC + TMO));
        check("fault_pll_reset", pll_reset_a, 1);
        check("fault_rst", rst_out_a, 3'b111);
        pll_lock = 1'b1;
        repeat (100) tick();
        check("fault_hold", fault_a, 1);
        check("fault_hold_state", state_a, P_FAULT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
